store_unit: RTL and testbench

- Write-side counterpart of the load path's byte/halfword extraction. It accepts one store request from the execute stage, aligns the store data and builds the byte-lane write mask.
- Issues one or two word-aligned write beats to the data-memory write port; two beats are used when the access crosses a 32-bit word boundary.
- Returns a single completion/error response toward writeback.
- Sits between EXU and the data-memory write port, next to the existing load path.

---
 rtl/store_unit.sv | 135 +++++++++++++
 tb/tb_store_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Store path: aligns store data, builds byte-lane masks and issues one or two
// word-aligned write beats, then a single completion/error response.
module store_unit #(
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  storeop,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t      state;
  logic [31:0] b1_addr;
  logic [31:0] b1_data;
  logic [3:0]  b1_mask;
  logic        split_q;

  logic [3:0]  nmask;
  logic        illegal;
  logic [31:0] wmask32;
  logic [7:0]  m8;
  logic [63:0] d64;
  logic        split;
  logic [31:0] b0_addr;

  always_comb begin
    illegal = 1'b0;
    nmask   = 4'h0;
    case (storeop)
      3'd0:    nmask = 4'b0001;
      3'd1:    nmask = 4'b0011;
      3'd2:    nmask = 4'b1111;
      default: illegal = 1'b1;
    endcase
  end

  // Lanes beyond the access size are zeroed before shifting into position.
  assign wmask32 = {{8{nmask[3]}}, {8{nmask[2]}}, {8{nmask[1]}}, {8{nmask[0]}}};
  assign m8      = {4'b0000, nmask} << waddr[1:0];
  assign d64     = {32'h0, wdata & wmask32} << {waddr[1:0], 3'b000};
  assign split   = |m8[7:4];
  assign b0_addr = {waddr[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      mem_wvalid <= 1'b0;
      mem_waddr  <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wmask  <= 8'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      b1_addr    <= 32'h0;
      b1_data    <= 32'h0;
      b1_mask    <= 4'h0;
      split_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (illegal || (split && !ALLOW_MISALIGN)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state      <= BEAT0;
              mem_wvalid <= 1'b1;
              mem_waddr  <= b0_addr;
              mem_wdata  <= d64[31:0];
              mem_wmask  <= {4'b0000, m8[3:0]};
              b1_addr    <= b0_addr + 32'd4;
              b1_data    <= d64[63:32];
              b1_mask    <= m8[7:4];
              split_q    <= split;
            end
          end
        end
        BEAT0: begin
          if (mem_wready) begin
            if (split_q) begin
              state     <= BEAT1;
              mem_waddr <= b1_addr;
              mem_wdata <= b1_data;
              mem_wmask <= {4'b0000, b1_mask};
            end else begin
              state      <= RESP;
              mem_wvalid <= 1'b0;
              mem_waddr  <= 32'h0;
              mem_wdata  <= 32'h0;
              mem_wmask  <= 8'h0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
            end
          end
        end
        BEAT1: begin
          if (mem_wready) begin
            state      <= RESP;
            mem_wvalid <= 1'b0;
            mem_waddr  <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wmask  <= 8'h0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: expected beats/responses are queued at issue
// and popped by a monitor on each output handshake.
module tb_store_unit;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  m;
  } beat_t;

  typedef struct {
    logic err;
    int   lat;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_valid1;
  logic        req_ready, req_ready1;
  logic [2:0]  storeop;
  logic [31:0] waddr, wdata;
  logic        mem_wvalid, mem_wvalid1;
  logic        mem_wready;
  logic [31:0] mem_waddr, mem_waddr1, mem_wdata, mem_wdata1;
  logic [7:0]  mem_wmask, mem_wmask1;
  logic        resp_valid, resp_valid1;
  logic        resp_ready;
  logic        resp_err, resp_err1;

  beat_t exp_b[$];
  resp_t exp_r[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    acc_cyc = 0;
  int    lat     = 0;
  logic  rv_prev = 1'b0;

  store_unit #(.ALLOW_MISALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .storeop(storeop), .waddr(waddr), .wdata(wdata),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err)
  );

  store_unit #(.ALLOW_MISALIGN(1'b0)) dut_strict (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .storeop(storeop), .waddr(waddr), .wdata(wdata),
    .mem_wvalid(mem_wvalid1), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr1), .mem_wdata(mem_wdata1), .mem_wmask(mem_wmask1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_err(resp_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
    beat_t b;
    b.a = a; b.d = d; b.m = m;
    exp_b.push_back(b);
  endtask

  task automatic push_resp(input logic err, input int l);
    resp_t r;
    r.err = err; r.lat = l;
    exp_r.push_back(r);
  endtask

  // Monitor: pops and compares on every beat and response handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      rv_prev = 1'b0;
    end else begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (mem_wvalid && mem_wready) begin
        if (exp_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: got addr 0x%08h data 0x%08h mask 0x%02h, expected none",
                   mem_waddr, mem_wdata, mem_wmask);
        end else begin
          beat_t e;
          e = exp_b.pop_front();
          chk("beat_addr", mem_waddr, e.a);
          chk("beat_data", mem_wdata, e.d);
          chk("beat_mask", {24'h0, mem_wmask}, {24'h0, e.m});
        end
      end
      if (resp_valid && !rv_prev) lat = cyc - acc_cyc;
      rv_prev = resp_valid;
      if (resp_valid && resp_ready) begin
        if (exp_r.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_resp: got err %0d, expected none", resp_err);
        end else begin
          resp_t r;
          r = exp_r.pop_front();
          chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
          chk("resp_latency", lat, r.lat);
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    storeop = op; waddr = a; wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got req_ready 0, expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_b.size() == 0 && exp_r.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got %0d beats %0d resps pending, expected 0",
               exp_b.size(), exp_r.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_mem_wvalid"}, {31'h0, mem_wvalid}, 32'h0);
    chk({tag, "_mem_waddr"}, mem_waddr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_wmask"}, {24'h0, mem_wmask}, 32'h0);
    chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_resp_err"}, {31'h0, resp_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0;
    storeop = 3'd0; waddr = 32'h0; wdata = 32'h0;
    mem_wready = 1'b1; resp_ready = 1'b1;
    #12;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned word
    push_beat(32'h8000_0004, 32'hDEAD_BEEF, 8'h0F);
    push_resp(1'b0, 2);
    send(3'd2, 32'h8000_0004, 32'hDEAD_BEEF);
    wait_done();

    // Byte at lane 3
    push_beat(32'h8000_0000, 32'hAB00_0000, 8'h08);
    push_resp(1'b0, 2);
    send(3'd0, 32'h8000_0003, 32'h1234_56AB);
    wait_done();

    // Halfword at lane 2, no split
    push_beat(32'h0000_0010, 32'h5678_0000, 8'h0C);
    push_resp(1'b0, 2);
    send(3'd1, 32'h0000_0012, 32'hABCD_5678);
    wait_done();

    // Halfword crossing a word boundary
    push_beat(32'h8000_0000, 32'h3400_0000, 8'h08);
    push_beat(32'h8000_0004, 32'h0000_0012, 8'h01);
    push_resp(1'b0, 3);
    send(3'd1, 32'h8000_0003, 32'hFFFF_1234);
    wait_done();

    // Word crossing the top of the address space
    push_beat(32'hFFFF_FFFC, 32'hC3D4_0000, 8'h0C);
    push_beat(32'h0000_0000, 32'h0000_A1B2, 8'h03);
    push_resp(1'b0, 3);
    send(3'd2, 32'hFFFF_FFFE, 32'hA1B2_C3D4);
    wait_done();

    // Illegal op with response held off
    resp_ready = 1'b0;
    push_resp(1'b1, 1);
    send(3'd3, 32'h0000_0100, 32'h1111_1111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("hold_resp_err", {31'h0, resp_err}, 32'h1);
      chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
      chk("hold_mem_wvalid", {31'h0, mem_wvalid}, 32'h0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_done();

    // Strict instance: crossing store is rejected without a beat
    storeop = 3'd1; waddr = 32'h8000_0003; wdata = 32'hFFFF_1234; req_valid1 = 1'b1;
    @(negedge clk);
    chk("strict_req_ready", {31'h0, req_ready1}, 32'h1);
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    @(negedge clk);
    chk("strict_resp_valid", {31'h0, resp_valid1}, 32'h1);
    chk("strict_resp_err", {31'h0, resp_err1}, 32'h1);
    chk("strict_mem_wvalid", {31'h0, mem_wvalid1}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("strict_idle_resp_valid", {31'h0, resp_valid1}, 32'h0);
    chk("strict_idle_mem_wvalid", {31'h0, mem_wvalid1}, 32'h0);
    chk("strict_idle_req_ready", {31'h0, req_ready1}, 32'h1);
    @(posedge clk); #1;

    // Stall in BEAT0, then reset mid-beat
    mem_wready = 1'b0;
    send(3'd2, 32'h0000_0040, 32'h1122_3344);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wvalid", {31'h0, mem_wvalid}, 32'h1);
      chk("stall_waddr", mem_waddr, 32'h0000_0040);
      chk("stall_wdata", mem_wdata, 32'h1122_3344);
      chk("stall_wmask", {24'h0, mem_wmask}, 32'h0F);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    mem_wready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;

    push_beat(32'h0000_0044, 32'h5566_7788, 8'h0F);
    push_resp(1'b0, 2);
    send(3'd2, 32'h0000_0044, 32'h5566_7788);
    wait_done();

    repeat (3) @(negedge clk);
    chk("beats_left", exp_b.size(), 32'h0);
    chk("resps_left", exp_r.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
